// File: rtl/rf_wb_ctrl_pkg.sv
// Shared constants and types for the register-file write-back controller.
// The struct widths follow the default 32x32 register file.
package rf_ctrl_pkg;

    localparam int NUM_SRC = 3;
    localparam int AW      = 5;
    localparam int DW      = 32;
    localparam int NREGS   = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

    typedef logic [$clog2(NUM_SRC)-1:0] rr_ptr_t;

endpackage

// File: rtl/rf_wb_ctrl_if.sv
// Write-back source bus: packed per-source valid/ready handshake with address and data.
// Sources drive the master modport; the controller takes the slave modport.
interface rf_wb_ctrl_if #(
    parameter int NUM_SRC = rf_ctrl_pkg::NUM_SRC,
    parameter int AW      = rf_ctrl_pkg::AW,
    parameter int DW      = rf_ctrl_pkg::DW
);
    import rf_ctrl_pkg::*;

    logic [NUM_SRC-1:0]    src_valid;
    logic [NUM_SRC-1:0]    src_ready;
    logic [NUM_SRC*AW-1:0] src_addr;
    logic [NUM_SRC*DW-1:0] src_data;

    modport master (
        output src_valid,
        output src_addr,
        output src_data,
        input  src_ready
    );

    modport slave (
        input  src_valid,
        input  src_addr,
        input  src_data,
        output src_ready
    );

endinterface

// File: rtl/rf_wb_ctrl_arb.sv
// Round-robin arbiter: one-hot grant searched from the pointer; the pointer
// moves past the granted requester whenever adv reports a completed transfer.
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt,
    output logic [PW-1:0] ptr
);
    import rf_ctrl_pkg::*;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] gidx;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        gidx  = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_q) + k) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gidx     = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv) begin
            ptr_d = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-back controller: round-robin merge of write-back sources onto the single
// register-file write port, plus the pending-write scoreboard used for issue stalls.
module rf_wb_ctrl #(
    parameter int NUM_SRC = rf_ctrl_pkg::NUM_SRC,
    parameter int AW      = rf_ctrl_pkg::AW,
    parameter int DW      = rf_ctrl_pkg::DW
) (
    input  logic            clk,
    input  logic            rst,
    rf_wb_ctrl_if.slave     wb,
    output logic            rf_we,
    output logic [AW-1:0]   rf_dst_addr,
    output logic [DW-1:0]   rf_dst,
    input  logic            alloc_en,
    input  logic [AW-1:0]   alloc_addr,
    input  logic [AW-1:0]   chk0_addr,
    input  logic [AW-1:0]   chk1_addr,
    output logic            chk0_busy,
    output logic            chk1_busy,
    output logic [2**AW-1:0] busy,
    output logic            idle,
    output logic            err
);
    import rf_ctrl_pkg::*;

    localparam int NR = 2**AW;
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    if (AW != rf_ctrl_pkg::AW || DW != rf_ctrl_pkg::DW) begin : g_width_chk
        $error("rf_wb_ctrl: AW/DW must match rf_ctrl_pkg::wb_req_t");
    end

    logic [NUM_SRC-1:0] gnt;
    logic [NUM_SRC-1:0] ready;
    logic [PW-1:0]      rr_ptr;
    logic               xfer;
    logic               sel_nz;
    logic               alloc_ok;
    logic               clr_hits_alloc;
    wb_req_t            sel;
    wb_req_t            out_q, out_d;
    logic               we_q, we_d;
    logic [NR-1:0]      busy_q, busy_d;
    logic               err_q, err_d;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (wb.src_valid),
        .adv (xfer),
        .gnt (gnt),
        .ptr (rr_ptr)
    );

    // Grants are masked during reset so nothing is accepted while state is cleared.
    assign ready        = rst ? '0 : gnt;
    assign wb.src_ready = ready;
    assign xfer         = |ready;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ready[i]) begin
                sel.addr = wb.src_addr[i*AW +: AW];
                sel.data = wb.src_data[i*DW +: DW];
            end
        end
    end

    assign sel_nz         = (sel.addr != '0);
    assign alloc_ok       = alloc_en && !rst && (alloc_addr != '0);
    assign clr_hits_alloc = we_q && (out_q.addr == alloc_addr);

    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[out_q.addr] = 1'b0;
        end
        // Applied after the clear so a same-cycle alloc to the same register wins.
        if (alloc_ok) begin
            busy_d[alloc_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
        we_d  = xfer && sel_nz;
        out_d = xfer ? sel : out_q;
        err_d = err_q
              | (alloc_ok && busy_q[alloc_addr] && !clr_hits_alloc)
              | (xfer && sel_nz && !busy_q[sel.addr]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            out_q  <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            we_q   <= we_d;
            out_q  <= out_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    // The bypass term mirrors the register file's same-cycle write forwarding.
    assign chk0_busy   = busy_q[chk0_addr] && !(we_q && (out_q.addr == chk0_addr));
    assign chk1_busy   = busy_q[chk1_addr] && !(we_q && (out_q.addr == chk1_addr));
    assign rf_we       = we_q;
    assign rf_dst_addr = out_q.addr;
    assign rf_dst      = out_q.data;
    assign busy        = busy_q;
    assign err         = err_q;
    assign idle        = (busy_q == '0) && !we_q;

    ptr_in_range: assert property (@(posedge clk) disable iff (rst) int'(rr_ptr) < NUM_SRC);

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: directed scenarios plus a randomized run
// compared against a behavioural model of arbitration and the scoreboard.
module tb_rf_wb_ctrl;
    import rf_ctrl_pkg::*;

    localparam int N = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              rf_we;
    logic [AW-1:0]     rf_dst_addr;
    logic [DW-1:0]     rf_dst;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic [AW-1:0]     chk0_addr;
    logic [AW-1:0]     chk1_addr;
    logic              chk0_busy;
    logic              chk1_busy;
    logic [NREGS-1:0]  busy;
    logic              idle;
    logic              err;
    int                tests = 0;
    int                fails = 0;

    rf_wb_ctrl_if #(.NUM_SRC(N), .AW(AW), .DW(DW)) wb_bus ();

    rf_wb_ctrl #(.NUM_SRC(N), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (wb_bus),
        .rf_we       (rf_we),
        .rf_dst_addr (rf_dst_addr),
        .rf_dst      (rf_dst),
        .alloc_en    (alloc_en),
        .alloc_addr  (alloc_addr),
        .chk0_addr   (chk0_addr),
        .chk1_addr   (chk1_addr),
        .chk0_busy   (chk0_busy),
        .chk1_busy   (chk1_busy),
        .busy        (busy),
        .idle        (idle),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_bus.src_valid = '0;
        wb_bus.src_addr  = '0;
        wb_bus.src_data  = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        chk0_addr  = '0;
        chk1_addr  = '0;
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_bus.src_valid[i]        = 1'b1;
        wb_bus.src_addr[i*AW +: AW] = a;
        wb_bus.src_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_src(i, AW'(i + 1), DW'($urandom));
        for (int c = 0; c < 2; c++) begin
            tick();
            tests++;
            if (wb_bus.src_ready !== 3'b000) begin
                fails++; $display("FAIL reset_ready c%0d: got %b want 000", c, wb_bus.src_ready);
            end
            tests++;
            if (rf_we !== 1'b0) begin
                fails++; $display("FAIL reset_we c%0d: got %b want 0", c, rf_we);
            end
        end
        tests++;
        if (rf_dst_addr !== '0 || rf_dst !== '0 || busy !== '0 || err !== 1'b0 || idle !== 1'b1) begin
            fails++;
            $display("FAIL reset_values: addr=%0h data=%0h busy=%0h err=%b idle=%b want 0/0/0/0/1",
                     rf_dst_addr, rf_dst, busy, err, idle);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (wb_bus.src_ready !== 3'b001) begin
            fails++; $display("FAIL reset_release_ready: got %b want 001", wb_bus.src_ready);
        end
        wb_bus.src_valid = '0;
        tick();
    endtask

    task automatic test_reset_midop();
        do_reset();
        alloc_en = 1'b1; alloc_addr = 5'd3;
        tick();
        alloc_en = 1'b0;
        set_src(0, 5'd3, 32'hCAFE_0003);
        tick();
        wb_bus.src_valid = '0;
        set_src(1, 5'd4, 32'h0000_0004);
        rst = 1'b1;
        #1;
        tests++;
        if (rf_we !== 1'b1 || wb_bus.src_ready !== 3'b000) begin
            fails++; $display("FAIL midop_before: we=%b ready=%b want 1/000", rf_we, wb_bus.src_ready);
        end
        tick();
        tests++;
        if (rf_we !== 1'b0 || busy !== '0) begin
            fails++; $display("FAIL midop_after: we=%b busy=%0h want 0/0", rf_we, busy);
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_fairness();
        logic [DW-1:0] d [N];
        logic [N-1:0]  exp_rdy;
        do_reset();
        for (int i = 0; i < N; i++) begin
            d[i] = DW'($urandom);
            set_src(i, AW'(i + 1), d[i]);
        end
        for (int k = 0; k < 9; k++) begin
            #1;
            exp_rdy = N'(1 << (k % 3));
            tests++;
            if (wb_bus.src_ready !== exp_rdy) begin
                fails++; $display("FAIL fair_ready k%0d: got %b want %b", k, wb_bus.src_ready, exp_rdy);
            end
            if (k > 0) begin
                tests++;
                if (rf_we !== 1'b1 || rf_dst_addr !== AW'((k - 1) % 3 + 1) || rf_dst !== d[(k - 1) % 3]) begin
                    fails++;
                    $display("FAIL fair_out k%0d: we=%b addr=%0d data=%h want 1/%0d/%h",
                             k, rf_we, rf_dst_addr, rf_dst, (k - 1) % 3 + 1, d[(k - 1) % 3]);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_scoreboard();
        do_reset();
        alloc_en = 1'b1; alloc_addr = 5'd5; chk0_addr = 5'd5;
        tick();
        alloc_en = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) set_src(1, 5'd5, 32'hDEADBEEF);
            #1;
            tests++;
            if (chk0_busy !== 1'b1) begin
                fails++; $display("FAIL sb_chk_busy c%0d: got %b want 1", c, chk0_busy);
            end
            if (c == 3) begin
                tests++;
                if (wb_bus.src_ready !== 3'b010) begin
                    fails++; $display("FAIL sb_ready: got %b want 010", wb_bus.src_ready);
                end
            end
            tick();
        end
        wb_bus.src_valid = '0;
        #1;
        tests++;
        if (rf_we !== 1'b1 || rf_dst_addr !== 5'd5 || rf_dst !== 32'hDEADBEEF) begin
            fails++; $display("FAIL sb_write: we=%b addr=%0d data=%h want 1/5/deadbeef", rf_we, rf_dst_addr, rf_dst);
        end
        tests++;
        if (chk0_busy !== 1'b0 || busy[5] !== 1'b1 || idle !== 1'b0) begin
            fails++; $display("FAIL sb_bypass: chk0=%b busy5=%b idle=%b want 0/1/0", chk0_busy, busy[5], idle);
        end
        tick();
        tests++;
        if (busy[5] !== 1'b0 || idle !== 1'b1 || err !== 1'b0) begin
            fails++; $display("FAIL sb_clear: busy5=%b idle=%b err=%b want 0/1/0", busy[5], idle, err);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        alloc_en = 1'b1; alloc_addr = 5'd7;
        tick();
        alloc_en = 1'b0;
        set_src(2, 5'd7, DW'($urandom));
        #1;
        tests++;
        if (wb_bus.src_ready !== 3'b100) begin
            fails++; $display("FAIL same_ready: got %b want 100", wb_bus.src_ready);
        end
        tick();
        wb_bus.src_valid = '0;
        alloc_en = 1'b1; alloc_addr = 5'd7; chk0_addr = 5'd7;
        #1;
        tests++;
        if (rf_we !== 1'b1 || rf_dst_addr !== 5'd7 || chk0_busy !== 1'b0) begin
            fails++; $display("FAIL same_write: we=%b addr=%0d chk0=%b want 1/7/0", rf_we, rf_dst_addr, chk0_busy);
        end
        tick();
        alloc_en = 1'b0;
        #1;
        tests++;
        if (busy[7] !== 1'b1 || err !== 1'b0 || chk0_busy !== 1'b1) begin
            fails++; $display("FAIL same_alloc_wins: busy7=%b err=%b chk0=%b want 1/0/1", busy[7], err, chk0_busy);
        end
    endtask

    task automatic test_reg0();
        do_reset();
        set_src(0, 5'd0, 32'h0000_1234);
        chk1_addr = 5'd0;
        #1;
        tests++;
        if (wb_bus.src_ready !== 3'b001 || chk1_busy !== 1'b0) begin
            fails++; $display("FAIL r0_accept: ready=%b chk1=%b want 001/0", wb_bus.src_ready, chk1_busy);
        end
        tick();
        wb_bus.src_valid = '0;
        alloc_en = 1'b1; alloc_addr = 5'd0;
        #1;
        tests++;
        if (rf_we !== 1'b0) begin
            fails++; $display("FAIL r0_we: got %b want 0", rf_we);
        end
        tick();
        alloc_en = 1'b0;
        #1;
        tests++;
        if (busy !== '0 || err !== 1'b0 || idle !== 1'b1 || chk1_busy !== 1'b0) begin
            fails++; $display("FAIL r0_state: busy=%0h err=%b idle=%b chk1=%b want 0/0/1/0", busy, err, idle, chk1_busy);
        end
    endtask

    task automatic test_protocol_error();
        do_reset();
        set_src(1, 5'd9, DW'($urandom));
        #1;
        tests++;
        if (err !== 1'b0) begin
            fails++; $display("FAIL perr_before: got %b want 0", err);
        end
        tick();
        wb_bus.src_valid = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests++;
            if (err !== 1'b1) begin
                fails++; $display("FAIL perr_sticky c%0d: got %b want 1", c, err);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if (err !== 1'b0) begin
            fails++; $display("FAIL perr_reset: got %b want 0", err);
        end
        alloc_en = 1'b1; alloc_addr = 5'd4;
        tick();
        #1;
        tests++;
        if (err !== 1'b0) begin
            fails++; $display("FAIL waw_first: got %b want 0", err);
        end
        tick();
        alloc_en = 1'b0;
        #1;
        tests++;
        if (err !== 1'b1) begin
            fails++; $display("FAIL waw_err: got %b want 1", err);
        end
    endtask

    task automatic test_random();
        logic [NREGS-1:0] m_busy, nb;
        logic             m_we, m_err, exp_c0, exp_c1;
        logic [AW-1:0]    m_addr;
        logic [DW-1:0]    m_data;
        rr_ptr_t          m_ptr;
        logic [N-1:0]     hold, exp_rdy;
        logic [AW-1:0]    sa [N];
        logic [DW-1:0]    sd [N];
        int               g, j;
        do_reset();
        m_busy = '0; m_we = 1'b0; m_err = 1'b0; m_addr = '0; m_data = '0; m_ptr = '0; hold = '0;
        for (int i = 0; i < N; i++) begin
            sa[i] = '0; sd[i] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++) begin
                if (!hold[i] && $urandom_range(0, 2) != 0) begin
                    hold[i] = 1'b1;
                    sa[i]   = AW'($urandom_range(0, 7));
                    sd[i]   = DW'($urandom);
                end
                wb_bus.src_valid[i]         = hold[i];
                wb_bus.src_addr[i*AW +: AW] = sa[i];
                wb_bus.src_data[i*DW +: DW] = sd[i];
            end
            alloc_en   = ($urandom_range(0, 3) == 0);
            alloc_addr = AW'($urandom_range(0, 7));
            chk0_addr  = AW'($urandom_range(0, 7));
            chk1_addr  = AW'($urandom_range(0, 7));
            #1;
            g = -1;
            if (!rst) begin
                for (int k = 0; k < N; k++) begin
                    j = (int'(m_ptr) + k) % N;
                    if (g < 0 && hold[j]) g = j;
                end
            end
            exp_rdy = (g < 0) ? '0 : N'(1 << g);
            exp_c0  = m_busy[chk0_addr] && !(m_we && m_addr == chk0_addr);
            exp_c1  = m_busy[chk1_addr] && !(m_we && m_addr == chk1_addr);
            tests++;
            if (wb_bus.src_ready !== exp_rdy) begin
                fails++; $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, wb_bus.src_ready, exp_rdy);
            end
            tests++;
            if (rf_we !== m_we || rf_dst_addr !== m_addr || rf_dst !== m_data) begin
                fails++;
                $display("FAIL rnd_out cyc%0d: we=%b addr=%0d data=%h want %b/%0d/%h",
                         cyc, rf_we, rf_dst_addr, rf_dst, m_we, m_addr, m_data);
            end
            tests++;
            if (busy !== m_busy || idle !== (m_busy == '0 && !m_we) || err !== m_err) begin
                fails++;
                $display("FAIL rnd_sb cyc%0d: busy=%h idle=%b err=%b want %h/%b/%b",
                         cyc, busy, idle, err, m_busy, (m_busy == '0 && !m_we), m_err);
            end
            tests++;
            if (chk0_busy !== exp_c0 || chk1_busy !== exp_c1) begin
                fails++; $display("FAIL rnd_chk cyc%0d: got %b%b want %b%b", cyc, chk0_busy, chk1_busy, exp_c0, exp_c1);
            end
            if (rst) begin
                m_busy = '0; m_we = 1'b0; m_err = 1'b0; m_addr = '0; m_data = '0; m_ptr = '0;
            end else begin
                if (alloc_en && alloc_addr != '0 && m_busy[alloc_addr] && !(m_we && m_addr == alloc_addr)) m_err = 1'b1;
                if (g >= 0 && sa[g] != '0 && !m_busy[sa[g]]) m_err = 1'b1;
                nb = m_busy;
                if (m_we) nb[m_addr] = 1'b0;
                if (alloc_en && alloc_addr != '0) nb[alloc_addr] = 1'b1;
                m_busy = nb;
                m_we   = (g >= 0) && (sa[g] != '0);
                if (g >= 0) begin
                    m_addr  = sa[g];
                    m_data  = sd[g];
                    hold[g] = 1'b0;
                    m_ptr   = rr_ptr_t'((g + 1) % N);
                end
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_reset_midop();
        test_fairness();
        test_scoreboard();
        test_same_cycle();
        test_reg0();
        test_protocol_error();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
